// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state type, write-size codes and tag width for the system bus.
package bus_pkg;
  localparam int TAG_W = 4;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_BYTE = 2'b01;
  localparam logic [1:0] WR_HALF = 2'b10;
  localparam logic [1:0] WR_WORD = 2'b11;
endpackage

// File: rtl/sys_bus_ctrl_ce_divider.sv
// ce_divider: one-cycle CPU clock-enable every CE_DIV cycles, decoded from a counter register.
module ce_divider #(
  parameter int CE_DIV = 2
) (
  input  logic clk_50mhz,
  input  logic rst,
  output logic cpu_ce
);
  localparam int CW = CE_DIV > 1 ? $clog2(CE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CE_DIV - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_50mhz or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  // With CE_DIV=1 the counter is pinned at 0 == LAST, so the enable is constant high.
  assign cpu_ce = cnt == LAST;
endmodule

// File: rtl/sys_bus_ctrl.sv
// sys_bus_ctrl: CPU-to-slave bus controller with tag decode, req/ack handshake,
// access timeout with error reporting, and a programmable CPU clock-enable.
module sys_bus_ctrl
  import bus_pkg::*;
#(
  parameter int NSLV = 4,
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int CE_DIV = 2,
  parameter logic [NSLV*TAG_W-1:0] SLV_TAGS = {4'hA, 4'h2, 4'h1, 4'h0},
  parameter int TIMEOUT = 15
) (
  input  logic                 clk_50mhz,
  input  logic                 rst,
  output logic                 cpu_ce,
  input  logic [AW-1:0]        m_addr,
  input  logic [DW-1:0]        m_wdata,
  input  logic                 m_rd,
  input  logic [1:0]           m_wr,
  output logic [DW-1:0]        m_rdata,
  output logic                 m_ready,
  output logic                 m_err,
  output logic [NSLV-1:0]      s_sel,
  output logic [AW-TAG_W-1:0]  s_addr,
  output logic [DW-1:0]        s_wdata,
  output logic                 s_rd,
  output logic [1:0]           s_wr,
  input  logic [NSLV*DW-1:0]   s_rdata,
  input  logic [NSLV-1:0]      s_ack
);
  localparam int AL = AW - TAG_W;
  state_t state;
  logic [7:0] tcnt;
  logic req, conflict, hit, acked;
  logic [NSLV-1:0] dec_sel;
  logic [DW-1:0] rd_mux;
  ce_divider #(.CE_DIV(CE_DIV)) u_ce (
    .clk_50mhz(clk_50mhz),
    .rst(rst),
    .cpu_ce(cpu_ce)
  );
  assign req = m_rd || m_wr != WR_NONE;
  assign conflict = m_rd && m_wr != WR_NONE;
  assign acked = |(s_ack & s_sel);
  // Scanning from the top down lets the lowest matching slot win on duplicate tags.
  always_comb begin
    dec_sel = '0;
    hit = 1'b0;
    for (int i = NSLV - 1; i >= 0; i--)
      if (m_addr[AW-1 -: TAG_W] == SLV_TAGS[TAG_W*i +: TAG_W]) begin
        dec_sel = '0;
        dec_sel[i] = 1'b1;
        hit = 1'b1;
      end
  end
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NSLV; i++)
      rd_mux = rd_mux | (s_rdata[DW*i +: DW] & {DW{s_sel[i]}});
  end
  always_ff @(posedge clk_50mhz or posedge rst)
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      m_rdata <= '0;
      m_ready <= 1'b0;
      m_err <= 1'b0;
      s_sel <= '0;
      s_addr <= '0;
      s_wdata <= '0;
      s_rd <= 1'b0;
      s_wr <= WR_NONE;
    end else begin
      case (state)
        IDLE:
          if (req) begin
            if (conflict || !hit) begin
              state <= ERR;
              m_ready <= 1'b1;
              m_err <= 1'b1;
            end else begin
              state <= ACCESS;
              s_sel <= dec_sel;
              s_addr <= m_addr[AL-1:0];
              s_wdata <= m_wdata;
              s_rd <= m_rd;
              s_wr <= m_wr;
              tcnt <= '0;
            end
          end
        ACCESS:
          if (acked) begin
            state <= DONE;
            m_ready <= 1'b1;
            m_rdata <= s_rd ? rd_mux : m_rdata;
            s_sel <= '0;
            s_rd <= 1'b0;
            s_wr <= WR_NONE;
          end else if (tcnt == 8'(TIMEOUT)) begin
            state <= ERR;
            m_ready <= 1'b1;
            m_err <= 1'b1;
            s_sel <= '0;
            s_rd <= 1'b0;
            s_wr <= WR_NONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        default:
          if (cpu_ce) begin
            state <= IDLE;
            m_ready <= 1'b0;
            m_err <= 1'b0;
          end
      endcase
    end
endmodule

// File: tb/tb_sys_bus_ctrl.sv
// tb_sys_bus_ctrl: directed transfers with a response scoreboard, plus clock-enable
// and duplicate-tag checks on a second instance.
module tb_sys_bus_ctrl;
  localparam int TO = 15;
  logic clk_50mhz = 1'b0;
  logic rst = 1'b1;
  logic cpu_ce, m_rd, m_ready, m_err, s_rd;
  logic [31:0] m_addr, m_wdata, m_rdata, s_wdata;
  logic [1:0] m_wr, s_wr;
  logic [3:0] s_sel, s_ack;
  logic [27:0] s_addr;
  logic [127:0] s_rdata;
  logic cpu_ce2, m_rd2, m_ready2, m_err2, s_rd2;
  logic [31:0] m_addr2, m_rdata2, s_wdata2;
  logic [1:0] m_wr2, s_wr2;
  logic [3:0] s_sel2, s_ack2;
  logic [27:0] s_addr2;
  logic [127:0] s_rdata2;
  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];
  logic rdy_q = 1'b0;

  sys_bus_ctrl dut (
    .clk_50mhz(clk_50mhz), .rst(rst), .cpu_ce(cpu_ce),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_rd(s_rd), .s_wr(s_wr),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  sys_bus_ctrl #(.NSLV(4), .CE_DIV(5), .SLV_TAGS(16'hA2A0), .TIMEOUT(TO)) dut2 (
    .clk_50mhz(clk_50mhz), .rst(rst), .cpu_ce(cpu_ce2),
    .m_addr(m_addr2), .m_wdata(m_wdata), .m_rd(m_rd2), .m_wr(m_wr2),
    .m_rdata(m_rdata2), .m_ready(m_ready2), .m_err(m_err2),
    .s_sel(s_sel2), .s_addr(s_addr2), .s_wdata(s_wdata2), .s_rd(s_rd2), .s_wr(s_wr2),
    .s_rdata(s_rdata2), .s_ack(s_ack2)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rising m_ready consumes one expected {err, rdata}.
  always @(negedge clk_50mhz) begin
    if (m_ready && !rdy_q) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ready err=%0b rdata=%h expected no response", m_err, m_rdata);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({m_err, m_rdata} !== e) begin
          errors++;
          $display("FAIL sb_resp: got err=%0b rdata=%h expected err=%0b rdata=%h", m_err, m_rdata, e[32], e[31:0]);
        end
      end
    end
    rdy_q <= m_ready;
  end

  // Caller is at a negedge with the DUT idle; slot<0 means no slave ever acks.
  task automatic xfer(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic rd, input logic [1:0] wr, input int slot, input int ack_k,
                      input logic [31:0] rdv, input logic [3:0] exp_sel,
                      input logic exp_err, input logic [31:0] exp_rd);
    int cyc, strb, n, ce_cnt, exp_lat, exp_strb;
    m_addr = addr;
    m_wdata = wdata;
    m_rd = rd;
    m_wr = wr;
    if (slot >= 0) s_rdata[slot*32 +: 32] = rdv;
    sb.push_back({exp_err, exp_rd});
    exp_lat = (exp_sel == 4'b0) ? 1 : (slot < 0 ? TO + 2 : ack_k + 1);
    exp_strb = (exp_sel == 4'b0) ? 0 : (slot < 0 ? TO + 1 : ack_k);
    cyc = 0;
    strb = 0;
    while (!m_ready && cyc < 40) begin
      @(negedge clk_50mhz);
      cyc++;
      if (cyc == 1) begin
        chk({name, "_sel"}, s_sel, exp_sel);
        chk({name, "_strobes"}, {s_rd, s_wr}, exp_sel == 4'b0 ? 3'b0 : {rd, wr});
        if (exp_sel != 4'b0) chk({name, "_addr_wdata"}, {s_addr, s_wdata}, {addr[27:0], wdata});
      end
      if (s_sel != 4'b0) strb++;
      s_ack = (slot >= 0 && cyc == ack_k) ? 4'(1 << slot) : 4'b0;
    end
    chk({name, "_latency"}, cyc, exp_lat);
    chk({name, "_strobe_cycles"}, strb, exp_strb);
    m_rd = 1'b0;
    m_wr = 2'b00;
    n = 0;
    ce_cnt = 0;
    while (m_ready && n < 20) begin
      ce_cnt += int'(cpu_ce);
      @(negedge clk_50mhz);
      n++;
    end
    chk({name, "_ready_hold"}, {m_ready, 8'(ce_cnt)}, {1'b0, 8'd1});
  endtask

  task automatic ce_run(input string name);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk_50mhz);
      chk($sformatf("%s_ce2_c%0d", name, c), cpu_ce, c % 2 == 1);
      chk($sformatf("%s_ce5_c%0d", name, c), cpu_ce2, c % 5 == 4);
    end
  endtask

  initial begin
    int cyc;
    m_addr = '0; m_wdata = '0; m_rd = 1'b0; m_wr = 2'b00; s_rdata = '0; s_ack = '0;
    m_addr2 = '0; m_rd2 = 1'b0; m_wr2 = 2'b00; s_rdata2 = '0; s_ack2 = '0;
    @(negedge clk_50mhz);
    chk("reset_outs", {cpu_ce, m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_rd, s_wr}, '0);
    chk("reset_ce5", cpu_ce2, 1'b0);
    @(negedge clk_50mhz);
    rst = 1'b0;
    #1;
    ce_run("ce");
    rst = 1'b1;
    #1;
    chk("midrst_ce2", cpu_ce, 1'b0);
    chk("midrst_ce5", cpu_ce2, 1'b0);
    @(negedge clk_50mhz);
    rst = 1'b0;
    #1;
    ce_run("ce_restart");
    @(negedge clk_50mhz);
    xfer("rd_slot1", 32'h1000_0040, 32'h0, 1'b1, 2'b00, 1, 3, 32'hDEAD_BEEF, 4'b0010, 1'b0, 32'hDEAD_BEEF);
    xfer("wr_slot3", 32'hA000_0010, 32'h1234_5678, 1'b0, 2'b11, 3, 1, 32'hFFFF_FFFF, 4'b1000, 1'b0, 32'hDEAD_BEEF);
    xfer("no_tag", 32'h5000_0000, 32'h0, 1'b1, 2'b00, -1, 0, 32'h0, 4'b0000, 1'b1, 32'hDEAD_BEEF);
    xfer("rd_and_wr", 32'h1000_0000, 32'h55, 1'b1, 2'b01, -1, 0, 32'h0, 4'b0000, 1'b1, 32'hDEAD_BEEF);
    xfer("timeout", 32'h0000_0000, 32'h0, 1'b1, 2'b00, -1, 0, 32'h0, 4'b0001, 1'b1, 32'hDEAD_BEEF);
    xfer("wr_half", 32'h2000_0ABC, 32'hCAFE_0001, 1'b0, 2'b10, 2, 2, 32'h1111_1111, 4'b0100, 1'b0, 32'hDEAD_BEEF);
    m_addr = 32'h2000_0004;
    m_rd = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    chk("rst_acc_sel", {s_sel, s_rd}, {4'b0100, 1'b1});
    rst = 1'b1;
    #1;
    chk("rst_acc_outs", {m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_rd, s_wr, cpu_ce}, '0);
    m_rd = 1'b0;
    @(negedge clk_50mhz);
    rst = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    chk("rst_acc_idle", {m_ready, m_err, s_sel}, '0);
    xfer("rd_after_rst", 32'h2000_0008, 32'h0, 1'b1, 2'b00, 2, 2, 32'h0BAD_F00D, 4'b0100, 1'b0, 32'h0BAD_F00D);
    m_addr2 = 32'hA000_0000;
    m_rd2 = 1'b1;
    s_ack2 = 4'b1000;
    cyc = 0;
    while (!m_ready2 && cyc < 40) begin
      @(negedge clk_50mhz);
      cyc++;
      if (cyc == 1) chk("dup_sel", s_sel2, 4'b0010);
    end
    chk("dup_err", {m_ready2, m_err2}, 2'b11);
    chk("dup_latency", cyc, TO + 2);
    m_rd2 = 1'b0;
    s_ack2 = '0;
    repeat (8) @(negedge clk_50mhz);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of run expected completion within 2ms");
    $fatal(1, "watchdog expired");
  end
endmodule
